// File: rtl/fft_input_loader_pkg.sv
// Shared types and default sizes for the FFT input loader.
package fft_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int FFT_POINTS = 64;
  localparam int ADDR_WIDTH = 6;

  // Fill side: accept samples, zero-pad a short frame, or discard an overlong one
  typedef enum logic [1:0] {
    FILL = 2'd0,
    PAD  = 2'd1,
    DROP = 2'd2
  } fill_state_t;

  // Drain side: wait for a full bank, pulse start, then stream the burst
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BURST = 2'd2
  } drain_state_t;

  typedef struct packed {
    logic signed [DATA_WIDTH-1:0] re;
    logic signed [DATA_WIDTH-1:0] im;
  } cplx_t;

endpackage

// File: rtl/fft_frame_buffer.sv
// Two-bank sample store: one write port and one registered read port.
// Address is {bank, index}. The array itself is never reset; only the
// read register is, so the burst data outputs read 0 after reset.
module fft_frame_buffer #(
  parameter int DATA_WIDTH = fft_pkg::DATA_WIDTH,
  parameter int FFT_POINTS = fft_pkg::FFT_POINTS,
  parameter int ADDR_WIDTH = fft_pkg::ADDR_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_wr_en,
  input  logic [ADDR_WIDTH:0]     i_wr_addr,
  input  logic [2*DATA_WIDTH-1:0] i_wr_data,
  input  logic                    i_rd_en,
  input  logic [ADDR_WIDTH:0]     i_rd_addr,
  output logic [2*DATA_WIDTH-1:0] o_rd_data
);

  logic [2*DATA_WIDTH-1:0] r_mem [2*FFT_POINTS];
  logic [2*DATA_WIDTH-1:0] r_rd_data;

  // Storage write; no reset so the array maps onto block RAM
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Registered read; data appears the cycle after i_rd_en
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/fft_input_loader.sv
// Streams complex samples into a ping-pong frame buffer and replays each
// complete frame to the FFT controller as a gap-free burst after a start
// pulse. Optional feature macro: FFT_LOADER_ZERO_PAD_EN (short frames are
// zero-filled and delivered instead of being flagged and discarded).
module fft_input_loader #(
  parameter int DATA_WIDTH = fft_pkg::DATA_WIDTH,
  parameter int FFT_POINTS = fft_pkg::FFT_POINTS,
  parameter int ADDR_WIDTH = fft_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_real,
  input  logic [DATA_WIDTH-1:0] s_imag,
  input  logic                  s_last,
  input  logic                  fft_busy,
  output logic                  fft_start,
  output logic                  fft_data_valid,
  output logic [ADDR_WIDTH-1:0] fft_addr_in,
  output logic [DATA_WIDTH-1:0] fft_data_real,
  output logic [DATA_WIDTH-1:0] fft_data_imag,
  output logic                  frame_err
);
  import fft_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(FFT_POINTS - 1);

  fill_state_t             r_fill_state, w_fill_next;
  drain_state_t            r_drain_state, w_drain_next;
  logic                    r_wb, w_wb_next;
  logic                    r_rb, w_rb_next;
  logic [ADDR_WIDTH-1:0]   r_wr_idx, w_wr_idx_next;
  logic [1:0]              r_full, w_full_next;
  logic                    r_live;
  logic                    w_set_full, w_clr_full;
  logic                    r_frame_err, w_frame_err_next;
  logic                    r_start, w_start_next;
  logic                    r_valid, w_valid_next;
  logic [ADDR_WIDTH-1:0]   r_addr, w_addr_next;
  logic                    w_handshake;
  logic                    w_wr_en;
  logic [2*DATA_WIDTH-1:0] w_wr_data;
  logic                    w_rd_en;
  logic [ADDR_WIDTH-1:0]   w_rd_idx;
  logic [2*DATA_WIDTH-1:0] w_rd_data;

  // Ready depends only on registered state; r_live holds it low until the
  // first clock after reset release
  always_comb begin
    s_ready = 1'b0;
    if (r_live) begin
      case (r_fill_state)
        FILL:    s_ready = !r_full[r_wb];
        DROP:    s_ready = 1'b1;
        default: s_ready = 1'b0;
      endcase
    end
  end

  assign w_handshake = s_valid && s_ready;

  // Fill FSM: next state, write port and frame bookkeeping
  always_comb begin
    w_fill_next      = r_fill_state;
    w_wr_idx_next    = r_wr_idx;
    w_wb_next        = r_wb;
    w_set_full       = 1'b0;
    w_frame_err_next = 1'b0;
    w_wr_en          = 1'b0;
    w_wr_data        = {s_real, s_imag};
    unique case (r_fill_state)
      FILL: begin
        if (w_handshake) begin
          w_wr_en       = 1'b1;
          w_wr_idx_next = r_wr_idx + 1'b1;
          if (r_wr_idx == LAST_IDX) begin
            w_wr_idx_next = '0;
            if (s_last) begin
              w_set_full = 1'b1;
              w_wb_next  = !r_wb;
            end else begin
              w_fill_next = DROP;
            end
          end else if (s_last) begin
`ifdef FFT_LOADER_ZERO_PAD_EN
            w_fill_next = PAD;
`else
            w_frame_err_next = 1'b1;
            w_wr_idx_next    = '0;
`endif
          end
        end
      end
      PAD: begin
        w_wr_en       = 1'b1;
        w_wr_data     = '0;
        w_wr_idx_next = r_wr_idx + 1'b1;
        if (r_wr_idx == LAST_IDX) begin
          w_wr_idx_next = '0;
          w_set_full    = 1'b1;
          w_wb_next     = !r_wb;
          w_fill_next   = FILL;
        end
      end
      DROP: begin
        if (w_handshake && s_last) begin
          w_frame_err_next = 1'b1;
          w_wr_idx_next    = '0;
          w_fill_next      = FILL;
        end
      end
      default: w_fill_next = FILL;
    endcase
  end

  // Drain FSM: start pulse, then a burst with the read prefetched one cycle ahead
  always_comb begin
    w_drain_next = r_drain_state;
    w_rb_next    = r_rb;
    w_clr_full   = 1'b0;
    w_start_next = 1'b0;
    w_valid_next = 1'b0;
    w_addr_next  = r_addr;
    w_rd_en      = 1'b0;
    w_rd_idx     = '0;
    unique case (r_drain_state)
      IDLE: begin
        if (r_full[r_rb] && !fft_busy) begin
          w_drain_next = START;
          w_start_next = 1'b1;
        end
      end
      START: begin
        w_rd_en      = 1'b1;
        w_valid_next = 1'b1;
        w_addr_next  = '0;
        w_drain_next = BURST;
      end
      BURST: begin
        if (r_addr == LAST_IDX) begin
          w_clr_full   = 1'b1;
          w_rb_next    = !r_rb;
          w_addr_next  = '0;
          w_drain_next = IDLE;
        end else begin
          w_rd_en      = 1'b1;
          w_rd_idx     = r_addr + 1'b1;
          w_valid_next = 1'b1;
          w_addr_next  = r_addr + 1'b1;
        end
      end
      default: w_drain_next = IDLE;
    endcase
  end

  // Per-bank full flag: the fill side sets one bank while the drain side may clear the other
  for (genvar gi = 0; gi < 2; gi++) begin : g_full
    assign w_full_next[gi] = (w_set_full && (r_wb == 1'(gi))) ? 1'b1 :
                             (w_clr_full && (r_rb == 1'(gi))) ? 1'b0 :
                             r_full[gi];
  end

  // State, pointer and registered-output updates
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fill_state  <= FILL;
      r_drain_state <= IDLE;
      r_wb          <= 1'b0;
      r_rb          <= 1'b0;
      r_wr_idx      <= '0;
      r_full        <= '0;
      r_live        <= 1'b0;
      r_frame_err   <= 1'b0;
      r_start       <= 1'b0;
      r_valid       <= 1'b0;
      r_addr        <= '0;
    end else begin
      r_fill_state  <= w_fill_next;
      r_drain_state <= w_drain_next;
      r_wb          <= w_wb_next;
      r_rb          <= w_rb_next;
      r_wr_idx      <= w_wr_idx_next;
      r_full        <= w_full_next;
      r_live        <= 1'b1;
      r_frame_err   <= w_frame_err_next;
      r_start       <= w_start_next;
      r_valid       <= w_valid_next;
      r_addr        <= w_addr_next;
    end
  end

  fft_frame_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .FFT_POINTS (FFT_POINTS),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_frame_buffer (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_wr_en),
    .i_wr_addr ({r_wb, r_wr_idx}),
    .i_wr_data (w_wr_data),
    .i_rd_en   (w_rd_en),
    .i_rd_addr ({r_rb, w_rd_idx}),
    .o_rd_data (w_rd_data)
  );

  assign fft_start      = r_start;
  assign fft_data_valid = r_valid;
  assign fft_addr_in    = r_addr;
  assign fft_data_real  = w_rd_data[2*DATA_WIDTH-1:DATA_WIDTH];
  assign fft_data_imag  = w_rd_data[DATA_WIDTH-1:0];
  assign frame_err      = r_frame_err;

endmodule

// File: tb/tb_fft_input_loader.sv
// Scoreboard bench for fft_input_loader: the driver pushes expected burst
// samples as it sends frames; a negedge monitor pops and compares them.
module tb_fft_input_loader;
  import fft_pkg::*;

  logic        clk, rst;
  logic        s_valid, s_ready, s_last;
  logic [15:0] s_real, s_imag;
  logic        fft_busy, fft_start, fft_data_valid, frame_err;
  logic [5:0]  fft_addr_in;
  logic [15:0] fft_data_real, fft_data_imag;

  typedef struct {
    int    addr;
    cplx_t d;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   cyc = 0;
  int   hs_cyc = 0;
  int   start_seen = 0;
  int   err_seen = 0;
  int   burst_no = 0;
  int   exp_start_cyc = 0;
  bit   lat_armed = 0;

  fft_input_loader dut (
    .clk            (clk),
    .rst            (rst),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_real         (s_real),
    .s_imag         (s_imag),
    .s_last         (s_last),
    .fft_busy       (fft_busy),
    .fft_start      (fft_start),
    .fft_data_valid (fft_data_valid),
    .fft_addr_in    (fft_addr_in),
    .fft_data_real  (fft_data_real),
    .fft_data_imag  (fft_data_imag),
    .frame_err      (frame_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Monitor: pops the scoreboard on every burst sample and checks burst shape
  initial begin
    int   burst_len;
    bit   prev_valid;
    bit   prev_start;
    exp_t e;
    burst_len  = 0;
    prev_valid = 0;
    prev_start = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        burst_len  = 0;
        prev_valid = 0;
        prev_start = 0;
      end else begin
        if (frame_err) err_seen++;
        if (fft_start) begin
          start_seen++;
          if (lat_armed) begin
            check("start_latency", cyc, exp_start_cyc);
            lat_armed = 0;
          end
        end
        if (prev_start) check("valid_after_start", longint'({fft_data_valid, fft_addr_in}), 64);
        if (fft_data_valid) begin
          if (exp_q.size() == 0) begin
            total_cnt++;
            $display("FAIL unexpected_sample: got addr %0d, expected no burst", fft_addr_in);
          end else begin
            e = exp_q.pop_front();
            check("addr", fft_addr_in, e.addr);
            check("real", $signed(fft_data_real), e.d.re);
            check("imag", $signed(fft_data_imag), e.d.im);
          end
          burst_len++;
        end else if (prev_valid) begin
          burst_no++;
          $display("burst %0d ended after %0d samples", burst_no, burst_len);
          check("burst_len", burst_len, 64);
          burst_len = 0;
        end
        prev_valid = fft_data_valid;
        prev_start = fft_start;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One handshake; called and returns at posedge+1
  task automatic send(input int re, input int im, input bit last);
    int   g;
    logic hs;
    g       = 0;
    s_valid = 1'b1;
    s_real  = 16'(re);
    s_imag  = 16'(im);
    s_last  = last;
    do begin
      @(negedge clk);
      hs     = s_ready;
      hs_cyc = cyc;
      @(posedge clk);
      #1;
      g++;
    end while (!hs && g < 2000);
    if (!hs) check("handshake_timeout", hs, 1);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_frame(input int n, input int re0, input int re_step,
                            input int im0, input int im_step, input bit gaps,
                            input bit push);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      if (gaps && ((i * 7) % 10) < 3) idle(1);
      if (push && i < 64) begin
        e.addr = i;
        e.d.re = 16'(re0 + re_step * i);
        e.d.im = 16'(im0 + im_step * i);
        exp_q.push_back(e);
      end
      send(re0 + re_step * i, im0 + im_step * i, i == n - 1);
    end
    if (push) begin
      for (int i = n; i < 64; i++) begin
        e.addr = i;
        e.d.re = '0;
        e.d.im = '0;
        exp_q.push_back(e);
      end
    end
    $display("frame sent: %0d samples, first real %0d", n, re0);
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    do begin
      @(posedge clk);
      #1;
      g++;
    end while ((exp_q.size() != 0 || fft_data_valid) && g < 3000);
    check("drain_complete", exp_q.size(), 0);
    idle(3);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_s_ready"}, s_ready, 0);
    check({tag, "_start"}, fft_start, 0);
    check({tag, "_valid"}, fft_data_valid, 0);
    check({tag, "_addr"}, fft_addr_in, 0);
    check({tag, "_real"}, fft_data_real, 0);
    check({tag, "_imag"}, fft_data_imag, 0);
    check({tag, "_frame_err"}, frame_err, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got time %0t, expected completion earlier", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int st0, e0, t0, g;
    rst      = 1'b1;
    s_valid  = 1'b0;
    s_last   = 1'b0;
    s_real   = '0;
    s_imag   = '0;
    fft_busy = 1'b0;

    // Reset state and s_ready release timing
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("ready_low_first_cycle", s_ready, 0);
    @(negedge clk);
    check("ready_rises", s_ready, 1);
    @(posedge clk);
    #1;

    // Full ramp frame, start latency 2 cycles after the last handshake
    send_frame(64, 0, 1, 0, -1, 0, 1);
    exp_start_cyc = hs_cyc + 2;
    lat_armed     = 1;
    wait_drain();
    check("latency_armed_consumed", lat_armed, 0);

    // Back-to-back frames while the controller is busy
    fft_busy = 1'b1;
    t0  = cyc;
    st0 = start_seen;
    send_frame(64, 100, 1, 0, 1, 0, 1);
    send_frame(64, 200, 2, 50, -3, 0, 1);
    @(negedge clk);
    check("ready_low_both_full", s_ready, 0);
    while (cyc - t0 < 200) idle(1);
    check("ready_still_low", s_ready, 0);
    check("no_start_while_busy", start_seen, st0);
    fft_busy = 1'b0;
    wait_drain();
    check("two_starts_after_busy", start_seen, st0 + 2);

    // Upstream gaps are absorbed
    send_frame(64, 1, 3, 500, -1, 1, 1);
    wait_drain();

    // Short frame
    st0 = start_seen;
    e0  = err_seen;
`ifdef FFT_LOADER_ZERO_PAD_EN
    send_frame(40, 1000, 1, 0, 1, 0, 1);
    wait_drain();
    check("short_err_count", err_seen, e0);
    check("short_start_count", start_seen, st0 + 1);
`else
    send_frame(40, 1000, 1, 0, 1, 0, 0);
    idle(20);
    check("short_err_count", err_seen, e0 + 1);
    check("short_start_count", start_seen, st0);
`endif

    // Long frame is dropped, next frame delivered cleanly
    st0 = start_seen;
    e0  = err_seen;
    send_frame(70, 5000, 1, 7, 1, 0, 0);
    idle(20);
    check("long_err_count", err_seen, e0 + 1);
    check("long_no_start", start_seen, st0);
    send_frame(64, 2000, 1, 0, 5, 0, 1);
    wait_drain();

    // Reset in the middle of a burst
    send_frame(64, 3000, 1, -100, 1, 0, 1);
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!(fft_data_valid && fft_addr_in == 6'd20) && g < 500);
    check("reach_addr20", fft_addr_in, 20);
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    @(negedge clk);
    check_outputs_zero("midburst_reset");
    @(posedge clk);
    #1 rst = 1'b0;
    send_frame(64, 4000, -1, 9, 2, 0, 1);
    wait_drain();

    check("queue_empty_end", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
